tm1638_keyscan: RTL and testbench

Key-scan reader for the TM1638 LED/key controller; the read-direction companion of the display driver on the same STB/CLK/DIO bus. On request it issues the read-key command (0x42), turns DIO around, and shifts in the 4 key-scan bytes LSB-first. It decodes the 8 on-board keys and debounces them across consecutive scans. The top level arbitrates bus ownership via `start`/`busy` and combines `dio_o`/`dio_oe` into the pulled-up DIO pad.

---
 rtl/tm1638_keyscan.sv | 173 +++++++++++++++++
 tb/tb_tm1638_keyscan.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/tm1638_keyscan.sv
// TM1638 key-scan reader: sends read-key command 0x42, releases DIO, shifts in
// four key bytes LSB-first, decodes the 8 keys and debounces them across scans.
module tm1638_keyscan #(
    parameter int unsigned WAIT_TICKS = 4,
    parameter int unsigned DEBOUNCE   = 3
) (
    input  logic        clkinput,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        stb,
    output logic        clk,
    output logic        dio_o,
    output logic        dio_oe,
    input  logic        dio_i,
    output logic [31:0] raw_scan,
    output logic [7:0]  keys,
    output logic [7:0]  keys_db,
    output logic [7:0]  key_press
);

    localparam int unsigned CNT_MAX = (WAIT_TICKS > 64) ? WAIT_TICKS : 64;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);
    localparam int unsigned DB_W    = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);

    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(15);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_TICKS - 1);
    localparam logic [CNT_W-1:0] READ_LAST = CNT_W'(63);
    localparam logic [DB_W-1:0]  DB_LIM    = DB_W'(DEBOUNCE);
    localparam logic [7:0]       CMD_READ  = 8'h42;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WAIT,
        ST_READ,
        ST_END
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       cmd;
    logic [31:0]      shift;
    logic [7:0]       cand;
    logic [DB_W-1:0]  db_cnt;

    logic [7:0]       scan_keys;
    logic [7:0]       cand_next;
    logic [DB_W-1:0]  db_cnt_next;
    logic [7:0]       db_next;

    // Each key byte carries two keys: bit 0 -> even key, bit 4 -> odd key.
    function automatic logic [7:0] decode_keys(input logic [31:0] scan);
        logic [7:0] k;
        k = '0;
        for (int unsigned n = 0; n < 4; n++) begin
            k[2*n]   = scan[8*n];
            k[2*n+1] = scan[8*n+4];
        end
        return k;
    endfunction

    always_comb begin
        scan_keys   = decode_keys(shift);
        cand_next   = cand;
        db_cnt_next = db_cnt;
        if (scan_keys == cand) begin
            if (db_cnt < DB_LIM)
                db_cnt_next = db_cnt + DB_W'(1);
        end else begin
            cand_next   = scan_keys;
            db_cnt_next = DB_W'(1);
        end
        db_next = (db_cnt_next >= DB_LIM) ? cand_next : keys_db;
    end

    always_ff @(posedge clkinput or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            cmd       <= '0;
            shift     <= '0;
            cand      <= '0;
            db_cnt    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            stb       <= 1'b1;
            clk       <= 1'b1;
            dio_o     <= 1'b0;
            dio_oe    <= 1'b0;
            raw_scan  <= '0;
            keys      <= '0;
            keys_db   <= '0;
            key_press <= '0;
        end else begin
            done      <= 1'b0;
            key_press <= '0;
            case (state)
                ST_IDLE: begin
                    stb    <= 1'b1;
                    clk    <= 1'b1;
                    dio_oe <= 1'b0;
                    busy   <= 1'b0;
                    if (start) begin
                        stb   <= 1'b0;
                        cmd   <= CMD_READ;
                        busy  <= 1'b1;
                        cnt   <= '0;
                        state <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    dio_oe <= 1'b1;
                    if (!cnt[0]) begin
                        clk   <= 1'b0;
                        dio_o <= cmd[0];
                    end else begin
                        clk <= 1'b1;
                        cmd <= cmd >> 1;
                    end
                    if (cnt == CMD_LAST) begin
                        cnt   <= '0;
                        state <= ST_WAIT;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_WAIT: begin
                    dio_oe <= 1'b0;
                    clk    <= 1'b1;
                    if (cnt == WAIT_LAST) begin
                        cnt   <= '0;
                        state <= ST_READ;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_READ: begin
                    dio_oe <= 1'b0;
                    // Sample on the rising tick, a full tick after the falling one.
                    if (!cnt[0]) begin
                        clk <= 1'b0;
                    end else begin
                        clk   <= 1'b1;
                        shift <= {dio_i, shift[31:1]};
                    end
                    if (cnt == READ_LAST) begin
                        cnt   <= '0;
                        state <= ST_END;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_END: begin
                    stb       <= 1'b1;
                    clk       <= 1'b1;
                    dio_oe    <= 1'b0;
                    done      <= 1'b1;
                    raw_scan  <= shift;
                    keys      <= scan_keys;
                    cand      <= cand_next;
                    db_cnt    <= db_cnt_next;
                    keys_db   <= db_next;
                    key_press <= db_next & ~keys_db;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tm1638_keyscan.sv
// Bench for tm1638_keyscan: TM1638 bus model, directed key vectors, and a
// scoreboard monitor that checks every done pulse against queued expectations.
module tb_tm1638_keyscan;

    logic        clkinput = 1'b0;
    logic        rst_n;
    logic        start;
    logic        busy, done, stb, clk, dio_o, dio_oe, dio_i;
    logic [31:0] raw_scan;
    logic [7:0]  keys, keys_db, key_press;

    tm1638_keyscan #(.WAIT_TICKS(4), .DEBOUNCE(3)) dut (
        .clkinput (clkinput),
        .rst_n    (rst_n),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .stb      (stb),
        .clk      (clk),
        .dio_o    (dio_o),
        .dio_oe   (dio_oe),
        .dio_i    (dio_i),
        .raw_scan (raw_scan),
        .keys     (keys),
        .keys_db  (keys_db),
        .key_press(key_press)
    );

    always #5 clkinput = ~clkinput;

    typedef struct {
        logic [31:0] raw;
        logic [7:0]  k;
        logic [7:0]  db;
        logic [7:0]  press;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          dones  = 0;

    // TM1638 bus model with pull-up on the DIO pad
    logic [31:0] bus_data = '0;
    logic [7:0]  cap_cmd  = '0;
    int          cap_n    = 0;
    int          bit_idx  = 0;
    logic        drive_val = 1'b1;

    assign dio_i = dio_oe ? dio_o : drive_val;

    always @(negedge stb) begin
        cap_n   = 0;
        bit_idx = 0;
        cap_cmd = '0;
    end

    always @(posedge stb) drive_val = 1'b1;

    always @(posedge clk)
        if (stb === 1'b0 && dio_oe === 1'b1 && cap_n < 8) begin
            cap_cmd[cap_n[2:0]] = dio_o;
            cap_n++;
        end

    always @(negedge clk)
        if (stb === 1'b0 && dio_oe === 1'b0 && cap_n == 8 && bit_idx < 32) begin
            drive_val = bus_data[bit_idx];
            bit_idx++;
        end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    bit post_done = 1'b0;
    always @(negedge clkinput) begin
        if (post_done) begin
            post_done = 1'b0;
            check("press_one_cycle", {24'h0, key_press}, 32'h0);
        end
        if (rst_n === 1'b1 && done === 1'b1) begin
            dones++;
            if (sb.size() == 0) begin
                check("unexpected_done", 32'h1, 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("raw_scan", raw_scan, e.raw);
                check("keys", {24'h0, keys}, {24'h0, e.k});
                check("keys_db", {24'h0, keys_db}, {24'h0, e.db});
                check("key_press", {24'h0, key_press}, {24'h0, e.press});
                post_done = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clkinput);
        #1;
    endtask

    task automatic run_frame(input logic [31:0] data, input logic [7:0] ek,
                             input logic [7:0] edb, input logic [7:0] epr);
        int done_at, stb_rise, busy_fall, oe_first, oe_last, extra;
        exp_t e;
        e.raw = data; e.k = ek; e.db = edb; e.press = epr;
        sb.push_back(e);
        bus_data = data;
        done_at = -1; stb_rise = -1; busy_fall = -1; oe_first = -1; oe_last = -1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("accept_stb", {31'h0, stb}, 32'h0);
        check("accept_busy", {31'h0, busy}, 32'h1);
        for (int n = 1; n <= 200; n++) begin
            start = (n == 30);
            tick();
            if (dio_oe && oe_first < 0) oe_first = n;
            if (dio_oe) oe_last = n;
            if (stb && stb_rise < 0) stb_rise = n;
            if (done && done_at < 0) done_at = n;
            if (!busy) begin
                busy_fall = n;
                break;
            end
        end
        start = 1'b0;
        check("done_edge", 32'(done_at), 32'd85);
        check("stb_rise_edge", 32'(stb_rise), 32'd85);
        check("busy_fall_edge", 32'(busy_fall), 32'd86);
        check("oe_first", 32'(oe_first), 32'd1);
        check("oe_last", 32'(oe_last), 32'd16);
        check("cmd_byte", {24'h0, cap_cmd}, 32'h42);
        extra = 0;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (busy) extra++;
        end
        check("no_extra_frame", 32'(extra), 32'd0);
    endtask

    initial begin
        int dn_before, tcount, nd;
        int d_at[3];
        rst_n = 1'b0;
        start = 1'b0;
        #12;
        check("rst_stb", {31'h0, stb}, 32'h1);
        check("rst_clk", {31'h0, clk}, 32'h1);
        check("rst_oe", {31'h0, dio_oe}, 32'h0);
        check("rst_dio_o", {31'h0, dio_o}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_raw", raw_scan, 32'h0);
        check("rst_db", {24'h0, keys_db}, 32'h0);
        @(negedge clkinput);
        rst_n = 1'b1;
        tick();

        // Frame aborted by reset in the middle of READ
        bus_data = 32'hFFFF_FFFF;
        dn_before = dones;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (40) tick();
        rst_n = 1'b0;
        #1;
        check("abort_stb", {31'h0, stb}, 32'h1);
        check("abort_clk", {31'h0, clk}, 32'h1);
        check("abort_oe", {31'h0, dio_oe}, 32'h0);
        check("abort_busy", {31'h0, busy}, 32'h0);
        repeat (2) tick();
        @(negedge clkinput);
        rst_n = 1'b1;
        repeat (100) tick();
        check("abort_no_done", 32'(dones), 32'(dn_before));
        check("abort_raw", raw_scan, 32'h0);

        // Decode vector, then three scans of key 0 to pass the debounce
        run_frame(32'h1100_1001, 8'hC9, 8'h00, 8'h00);
        run_frame(32'h0000_0001, 8'h01, 8'h00, 8'h00);
        run_frame(32'h0000_0001, 8'h01, 8'h00, 8'h00);
        run_frame(32'h0000_0001, 8'h01, 8'h01, 8'h01);

        // Bounce: alternating scans never settle
        run_frame(32'h0000_0000, 8'h00, 8'h01, 8'h00);
        run_frame(32'h0000_0001, 8'h01, 8'h01, 8'h00);
        run_frame(32'h0000_00EE, 8'h00, 8'h01, 8'h00);
        run_frame(32'h0000_0001, 8'h01, 8'h01, 8'h00);

        // start held high: back-to-back frames, key 0 released and debounced
        begin
            exp_t e;
            e.raw = 32'h0; e.k = 8'h00; e.db = 8'h01; e.press = 8'h00;
            sb.push_back(e);
            sb.push_back(e);
            e.db = 8'h00;
            sb.push_back(e);
        end
        bus_data = 32'h0;
        start = 1'b1;
        nd = 0;
        tcount = 0;
        for (int n = 0; n < 400 && nd < 3; n++) begin
            tick();
            tcount++;
            if (done) begin
                d_at[nd] = tcount;
                nd++;
            end
        end
        start = 1'b0;
        check("held_frames", 32'(nd), 32'd3);
        check("period_1", 32'(d_at[1] - d_at[0]), 32'd86);
        check("period_2", 32'(d_at[2] - d_at[1]), 32'd86);
        tick();
        check("held_busy_off", {31'h0, busy}, 32'h0);
        repeat (20) tick();
        check("held_no_extra", {31'h0, busy}, 32'h0);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
